// File: rtl/cam_pkg.sv
// Shared definitions for the camera write path of the VGA frame buffer.
//   - default stored frame geometry
//   - bit positions used to reduce an RGB565 byte pair to RGB111
//   - capture FSM state encoding
//   - rgb565_to_111(): HI/LO camera bytes -> {R,G,B} buffer word
package cam_pkg;

  localparam int CAM_X_DEF = 256;
  localparam int CAM_Y_DEF = 256;

  // HI byte = R4..R0 G5..G3, LO byte = G2..G0 B4..B0.
  // Only the MSB of each colour survives the reduction.
  localparam int R_MSB_HI = 7;  // R4 in HI byte
  localparam int G_MSB_HI = 2;  // G5 in HI byte
  localparam int B_MSB_LO = 4;  // B4 in LO byte

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'd0,
    WAIT_LINE  = 3'd1,
    BYTE_LO    = 3'd2,
    BYTE_HI    = 3'd3,
    FRAME_END  = 3'd4
  } cam_state_e;

  function automatic logic [2:0] rgb565_to_111(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[R_MSB_HI], hi[G_MSB_HI], lo[B_MSB_LO]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera control line, followed
// by a third flop so that level changes can be reported as one-cycle pulses.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   lvl_o   synchronised level
//   rise_o  one-cycle pulse on a synchronised 0->1 change
//   fall_o  one-cycle pulse on a synchronised 1->0 change
module cam_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability stage, [1] synchronised level, [2] previous level
  logic [2:0] sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= '0;
    else         sh_q <= {sh_q[1:0], d_i};
  end

  assign lvl_o  = sh_q[1];
  assign rise_o =  sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/cam_frame_writer.sv
// Write side of the VGA frame buffer. Oversamples an OV7670-style camera
// interface in the system clock domain, assembles RGB565 byte pairs, reduces
// each pixel to RGB111 and writes it to the buffer at its raster address.
// Ports:
//   clk           system clock (at least 4x cam_pclk)
//   rst           asynchronous active-low reset
//   cam_pclk      camera pixel clock (asynchronous)
//   cam_vsync     camera frame sync, high = vertical blank
//   cam_href      camera line valid, high = active bytes
//   cam_data      camera byte
//   buf_addr      buffer write address {row, col}
//   buf_data      buffer write data {R,G,B}
//   buf_regwrite  one-cycle write strobe per stored pixel
//   frame_done    one-cycle pulse after a complete frame was stored
//   overflow      sticky flag: pixels were clipped in the current frame
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int CAM_SCREEN_X = CAM_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_Y_DEF,
  parameter int AW           = $clog2(CAM_SCREEN_X * CAM_SCREEN_Y),
  parameter int DW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] buf_addr,
  output logic [DW-1:0] buf_data,
  output logic          buf_regwrite,
  output logic          frame_done,
  output logic          overflow
);

  localparam int XW = $clog2(CAM_SCREEN_X);
  localparam int YW = $clog2(CAM_SCREEN_Y);

  // Counters carry one extra bit so they can sit at X / Y once the visible
  // area is exhausted instead of wrapping back into it.
  localparam logic [XW:0] COL_LIM = (XW+1)'(CAM_SCREEN_X);
  localparam logic [YW:0] ROW_LIM = (YW+1)'(CAM_SCREEN_Y);

  // ---------------------------------------------------------------------------
  // Synchronisers. cam_data goes through the same two stages as the control
  // lines so that data_s2_q is the byte seen alongside the synced pclk edge.
  // ---------------------------------------------------------------------------
  logic pclk_rise, pclk_lvl_unused, pclk_fall_unused;
  logic href_lvl, href_rise_unused, href_fall;
  logic vs_lvl_unused, vs_rise, vs_fall;
  logic [7:0] data_s1_q, data_s2_q;

  cam_sync_edge u_sync_pclk (
    .clk_i (clk), .rst_ni (rst), .d_i (cam_pclk),
    .lvl_o (pclk_lvl_unused), .rise_o (pclk_rise), .fall_o (pclk_fall_unused)
  );

  cam_sync_edge u_sync_href (
    .clk_i (clk), .rst_ni (rst), .d_i (cam_href),
    .lvl_o (href_lvl), .rise_o (href_rise_unused), .fall_o (href_fall)
  );

  cam_sync_edge u_sync_vsync (
    .clk_i (clk), .rst_ni (rst), .d_i (cam_vsync),
    .lvl_o (vs_lvl_unused), .rise_o (vs_rise), .fall_o (vs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      data_s1_q <= cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM and datapath
  // ---------------------------------------------------------------------------
  cam_state_e    state_q, state_d;
  logic [XW:0]   col_q, col_d;
  logic [YW:0]   row_q, row_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic          byte_stb;   // camera byte valid this cycle
  logic          line_end;   // href has gone low (edge, or seen low at a strobe)
  logic          in_bounds;  // current col/row lies inside the stored area
  logic [YW:0]   row_inc;    // saturating row + 1

  assign byte_stb  = pclk_rise &  href_lvl;
  assign line_end  = href_fall | (pclk_rise & ~href_lvl);
  assign in_bounds = (col_q < COL_LIM) && (row_q < ROW_LIM);
  assign row_inc   = (row_q >= ROW_LIM) ? row_q : row_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_FRAME;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    unique case (state_q)
      WAIT_FRAME: begin
        if (vs_fall) begin
          row_d   = '0;
          col_d   = '0;
          ovf_d   = 1'b0;
          state_d = WAIT_LINE;
        end
      end

      WAIT_LINE: begin
        if (vs_rise) begin
          state_d = FRAME_END;
        end else if (byte_stb) begin
          hi_d    = data_s2_q;
          state_d = BYTE_LO;
        end else if (href_fall) begin
          // href pulse that carried no bytes still consumes a row
          row_d = row_inc;
          col_d = '0;
        end
      end

      BYTE_LO: begin
        if (vs_rise) begin
          state_d = WAIT_FRAME;  // frame aborted mid-line
        end else if (byte_stb) begin
          if (in_bounds) begin
            we_d   = 1'b1;
            addr_d = AW'({row_q[YW-1:0], col_q[XW-1:0]});
            data_d = DW'(rgb565_to_111(hi_q, data_s2_q));
            col_d  = col_q + 1'b1;
          end else begin
            ovf_d  = 1'b1;
          end
          state_d = BYTE_HI;
        end else if (line_end) begin
          // odd byte count: the lone HI byte is discarded
          row_d   = row_inc;
          col_d   = '0;
          state_d = WAIT_LINE;
        end
      end

      BYTE_HI: begin
        if (vs_rise) begin
          state_d = WAIT_FRAME;
        end else if (byte_stb) begin
          hi_d    = data_s2_q;
          state_d = BYTE_LO;
        end else if (line_end) begin
          row_d   = row_inc;
          col_d   = '0;
          state_d = WAIT_LINE;
        end
      end

      FRAME_END: begin
        // only a frame that filled every stored line is reported
        done_d  = (row_q >= ROW_LIM);
        state_d = WAIT_FRAME;
      end

      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hi_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hi_q   <= hi_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  // Address and data are held after a write, so they are stable throughout
  // the single strobe cycle.
  assign buf_addr     = addr_q;
  assign buf_data     = data_q;
  assign buf_regwrite = we_q;
  assign frame_done   = done_q;
  assign overflow     = ovf_q;

endmodule
